// File: rtl/matrix_mode_fsm.sv
// Top-level mode sequencer: decodes mode/op on confirm, runs one sub-unit per pass,
// reports errors. Define MATRIX_MODE_FSM_TIMEOUT_EN to build the ACTIVE-phase watchdog.
module matrix_mode_fsm #(
  parameter int MODE_W      = 4,
  parameter int OP_W        = 3,
  parameter int NUM_OPS     = 5,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_select,
  input  logic [OP_W-1:0]   op_select,
  input  logic              confirm_btn,
  input  logic              back_btn,
  input  logic              input_done,
  input  logic              display_done,
  input  logic              calc_done,
  input  logic              calc_err,
  output logic [MODE_W-1:0] current_mode,
  output logic [OP_W-1:0]   op_type,
  output logic              input_en,
  output logic              calc_en,
  output logic              display_en,
  output logic              op_start,
  output logic              busy,
  output logic              err_flag,
  output logic [2:0]        err_code
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t state;
  logic   confirm_prev, back_prev;
  logic   confirm_rise, back_rise;
  logic   done_match, calc_mode, mode_bad, op_bad, calc_fault, wd_expire, active_exit;

  assign calc_mode   = (current_mode == MODE_W'(2));
  assign mode_bad    = (mode_select > MODE_W'(2));
  assign op_bad      = (32'(op_select) >= 32'(NUM_OPS));
  assign calc_fault  = calc_mode && calc_err;
  assign active_exit = done_match || calc_fault || back_rise || wd_expire;

  // Only the done of the unit that is currently running counts.
  always_comb begin
    done_match = 1'b0;
    case (current_mode)
      MODE_W'(0): done_match = input_done;
      MODE_W'(1): done_match = display_done;
      MODE_W'(2): done_match = calc_done;
      default:    done_match = 1'b0;
    endcase
  end

`ifdef MATRIX_MODE_FSM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);

  logic [WD_W-1:0] wd_cnt;

  // Held at zero outside ACTIVE, so it is already clear on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state != ACTIVE) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == ACTIVE) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      confirm_prev <= 1'b0;
      back_prev    <= 1'b0;
      confirm_rise <= 1'b0;
      back_rise    <= 1'b0;
      current_mode <= '0;
      op_type      <= '0;
      input_en     <= 1'b0;
      calc_en      <= 1'b0;
      display_en   <= 1'b0;
      op_start     <= 1'b0;
      busy         <= 1'b0;
      err_flag     <= 1'b0;
      err_code     <= 3'd0;
    end else begin
      confirm_prev <= confirm_btn;
      back_prev    <= back_btn;
      confirm_rise <= confirm_btn & ~confirm_prev;
      back_rise    <= back_btn & ~back_prev;
      op_start     <= 1'b0;

      case (state)
        IDLE: begin
          if (confirm_rise) begin
            if (mode_bad) begin
              state    <= ERROR;
              err_flag <= 1'b1;
              err_code <= 3'd1;
            end else if ((mode_select == MODE_W'(2)) && op_bad) begin
              state    <= ERROR;
              err_flag <= 1'b1;
              err_code <= 3'd2;
            end else begin
              state        <= ACTIVE;
              current_mode <= mode_select;
              if (mode_select == MODE_W'(2)) op_type <= op_select;
              input_en     <= (mode_select == MODE_W'(0));
              display_en   <= (mode_select == MODE_W'(1));
              calc_en      <= (mode_select == MODE_W'(2));
              op_start     <= 1'b1;
              busy         <= 1'b1;
            end
          end
        end

        ACTIVE: begin
          if (active_exit) begin
            input_en   <= 1'b0;
            calc_en    <= 1'b0;
            display_en <= 1'b0;
            busy       <= 1'b0;
          end
          if (done_match) begin
            state <= IDLE;
          end else if (calc_fault) begin
            state    <= ERROR;
            err_flag <= 1'b1;
            err_code <= 3'd4;
          end else if (back_rise) begin
            state <= IDLE;
          end else if (wd_expire) begin
            state    <= ERROR;
            err_flag <= 1'b1;
            err_code <= 3'd3;
          end
        end

        ERROR: begin
          if (confirm_rise || back_rise) begin
            state    <= IDLE;
            err_flag <= 1'b0;
            err_code <= 3'd0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/matrix_mode_fsm.md
# matrix_mode_fsm

Parametrised top-level mode sequencer for the matrix calculator. It decodes the mode and operation selected on the switches and steps through select, active and error phases. In the active phase it drives exactly one sub-unit (input, calculation or display) with a level enable plus a one-cycle start pulse, then waits for that sub-unit's done. It adds validation, abort, error reporting and an optional watchdog.

## Interface
Parameters:
- MODE_W, 4, width of mode_select / current_mode
- OP_W, 3, width of op_select / op_type
- NUM_OPS, 5, valid op codes are 0..NUM_OPS-1
- TIMEOUT_CYC, 100_000_000, watchdog limit in cycles (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_select  in  MODE_W  requested mode: 0 input, 1 display, 2 calc; all others invalid
- op_select  in  OP_W  requested operation, sampled only when entering calc
- confirm_btn  in  1  synchronised, debounced level; action on rising edge
- back_btn  in  1  synchronised, debounced level; action on rising edge
- input_done / display_done / calc_done  in  1 each  completion pulse from sub-unit
- calc_err  in  1  calc unit error pulse
- current_mode  out  MODE_W  latched mode, reset 0
- op_type  out  OP_W  latched op, reset 0
- input_en / calc_en / display_en  out  1 each  level enable, reset 0
- op_start  out  1  one-cycle pulse on entry to ACTIVE, reset 0
- busy  out  1  high in ACTIVE, reset 0
- err_flag  out  1  high in ERROR, reset 0
- err_code  out  3  0 none, 1 bad mode, 2 bad op, 3 timeout, 4 calc error; reset 0

## Operation
- Edge detect: confirm_btn/back_btn registered once; rise = level & ~prev. prev regs reset to 0.
- States: IDLE, ACTIVE, ERROR. Reset → IDLE.
- IDLE, confirm rise: mode_select > 2 → ERROR, code 1. mode 2 and op_select ≥ NUM_OPS → ERROR, code 2. Otherwise latch current_mode (and op_type if calc) and go to ACTIVE with op_start=1.
- current_mode/op_type change only on a successful latch; they hold through ERROR and IDLE.
- ACTIVE: only the enable matching current_mode is high. Exit priority per cycle:
  - matching done → IDLE;
  - else calc_err (calc mode) → ERROR, code 4;
  - else back rise → IDLE (abort);
  - else watchdog expiry → ERROR, code 3.
- Done pulses from non-matching units are ignored. confirm rise in ACTIVE is ignored.
- ERROR: err_flag=1 and err_code held. confirm or back rise → IDLE, which clears err_code to 0.
- All outputs are registered and update on the same edge as the state register.

## Timing
- confirm rise seen at edge k (btn high before k, prev low) → at edge k+1: state=ACTIVE, enable=1, op_start=1, busy=1.
- op_start falls at edge k+2. Enable stays high until exit.
- done high before edge d → at edge d: enable=0, busy=0, state=IDLE. A new confirm is accepted from edge d+1.
- Watchdog counter clears on ACTIVE entry and counts each ACTIVE cycle. At TIMEOUT_CYC cycles without exit, it goes to ERROR on that edge.
- done and timeout in the same cycle → done wins. done and back in the same cycle → done wins.
- Asynchronous reset mid-ACTIVE: all outputs drop to 0 immediately, no op_start glitch.

## Configuration
- MATRIX_MODE_FSM_TIMEOUT_EN defined: the watchdog counter and code 3 exist as above.
- Not defined: no counter is synthesised, ACTIVE waits indefinitely for done/calc_err/back, and code 3 is never produced.

## Test plan
- Reset, then confirm rise with mode=2, op=1 → next cycle calc_en=1, op_start=1 for exactly one cycle, op_type=1; calc_done pulse → calc_en=0, busy=0 on the following edge.
- confirm with mode=5 → err_flag=1, err_code=1, no enable; back rise → IDLE, err_code=0.
- mode=2, op=5 (NUM_OPS=5) → ERROR, code 2; current_mode keeps its previous value.
- mode=0 active, display_done pulse → ignored; input_done and back_btn rise in the same cycle → IDLE, no error.
- TIMEOUT_CYC=8 with the macro defined: mode=1, no done → err_code=3 exactly 8 cycles after ACTIVE entry. Without the macro, still ACTIVE after 20 cycles.
- Calc active, assert rst_n=0 asynchronously → all outputs 0 before the next clk edge.
